// File: rtl/fifo_frame_reader_pkg.sv
// fifo_frame_reader_pkg: shared state encoding and FIFO geometry for the frame reader
package fifo_frame_reader_pkg;
  localparam int FIFO_DATA_W = 11;
  localparam int FIFO_LVL_W = 14;
  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_e;
endpackage

// File: rtl/fifo_frame_reader_if.sv
// fifo_frame_reader_if: framed valid/ready output stream
interface fifo_frame_reader_if #(parameter int DATA_W = 11);
  logic valid;
  logic ready;
  logic sof;
  logic eof;
  logic [DATA_W-1:0] data;
  modport master (output valid, data, sof, eof, input ready);
  modport slave (input valid, data, sof, eof, output ready);
endinterface

// File: rtl/fifo_frame_skid.sv
// fifo_frame_skid: 2-entry valid/ready buffer absorbing FIFO read latency and backpressure
module fifo_frame_skid #(
  parameter int DATA_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occ_o
);
  logic [DATA_W-1:0] mem_q [2];
  logic rptr_q, wptr_q, pop;
  logic [1:0] occ_q, occ_d;
  assign out_valid_o = occ_q != 2'd0;
  assign pop = out_valid_o && out_ready_i;
  assign occ_d = occ_q + 2'(in_valid_i) - 2'(pop);
  assign out_data_o = mem_q[rptr_q];
  assign occ_o = occ_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_q <= '{default: '0};
      rptr_q <= 1'b0;
      wptr_q <= 1'b0;
      occ_q <= 2'd0;
    end else begin
      if (in_valid_i) mem_q[wptr_q] <= in_data_i;
      wptr_q <= wptr_q ^ in_valid_i;
      rptr_q <= rptr_q ^ pop;
      occ_q <= occ_d;
    end
endmodule

// File: rtl/fifo_frame_reader.sv
// fifo_frame_reader: waits for a full frame in the sample FIFO, then drains it as one framed burst
module fifo_frame_reader
  import fifo_frame_reader_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int LVL_W     = FIFO_LVL_W,
  parameter int FRAME_LEN = 1024,
  parameter int FCNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_i,
  output logic              fifo_rd_en_o,
  input  logic [DATA_W-1:0] fifo_rd_data_i,
  input  logic              fifo_rd_empty_i,
  input  logic [LVL_W-1:0]  fifo_rd_water_level_i,
  fifo_frame_reader_if.master m,
  output logic              busy_o,
  output logic [FCNT_W-1:0] frame_cnt_o
);
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] FL = CW'(FRAME_LEN);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  state_e state_q, state_d;
  logic [CW-1:0] issued_q, issued_d, deliv_q, deliv_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic infl_q, rd_en, pop, start, v;
  logic [1:0] occ;
  logic [DATA_W-1:0] d;
  assign pop = v && m.ready;
  assign start = enable_i && fifo_rd_water_level_i >= LVL_W'(FRAME_LEN);
  // Slot reserved for the word in flight; a same-cycle pop frees one, hence the ready->rd_en path.
  assign rd_en = state_q == BURST && !fifo_rd_empty_i && issued_q < FL &&
                 ({1'b0, occ} + 3'(infl_q)) < (3'd2 + 3'(pop));
  always_comb begin
    state_d = state_q;
    issued_d = issued_q + CW'(rd_en);
    deliv_d = deliv_q + CW'(pop);
    fcnt_d = fcnt_q;
    if (state_q == IDLE && start) begin
      state_d = BURST;
      issued_d = '0;
      deliv_d = '0;
    end
    if (state_q == BURST && rd_en && issued_q == LAST) state_d = DRAIN;
    if (state_q == DRAIN && pop && m.eof) begin
      state_d = IDLE;
      fcnt_d = fcnt_q + FCNT_W'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      issued_q <= '0;
      deliv_q <= '0;
      fcnt_q <= '0;
      infl_q <= 1'b0;
    end else begin
      state_q <= state_d;
      issued_q <= issued_d;
      deliv_q <= deliv_d;
      fcnt_q <= fcnt_d;
      infl_q <= rd_en;
    end
  fifo_frame_skid #(.DATA_W(DATA_W)) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (infl_q),
    .in_data_i   (fifo_rd_data_i),
    .out_ready_i (m.ready),
    .out_valid_o (v),
    .out_data_o  (d),
    .occ_o       (occ)
  );
  assign m.valid = v;
  assign m.data = d;
  assign m.sof = v && deliv_q == '0;
  assign m.eof = v && deliv_q == LAST;
  assign fifo_rd_en_o = rd_en;
  assign busy_o = state_q != IDLE;
  assign frame_cnt_o = fcnt_q;
endmodule

// File: tb/tb_fifo_frame_reader.sv
// tb_fifo_frame_reader: scoreboard bench with a queue-based FIFO model, 1024-word and 1-word frame instances
module tb_fifo_frame_reader;
  localparam int FL = 1024;
  logic clk = 1'b0;
  logic rst_n, rst1_n, enable, rd_en, empty, busy, rd_en1, empty1, busy1;
  logic [10:0] rd_data, rd_data1, pend, pend1, wd, wd1;
  logic [13:0] level, level1;
  logic [15:0] fcnt, fcnt1;
  logic [12:0] prev;
  logic rdy_rand, stall;
  logic [10:0] fq[$], eq[$], f1[$], e1[$];
  int chk = 0, err = 0, cyc = 0, k = 0, eofs = 0, rd_cnt = 0, max_out = 0;
  int first_rd = -1, last_eof = -1, gap_on = 0, lvl_cyc = 0;
  fifo_frame_reader_if #(.DATA_W(11)) m0 ();
  fifo_frame_reader_if #(.DATA_W(11)) m1 ();
  fifo_frame_reader #(.FRAME_LEN(FL)) u0 (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .fifo_rd_en_o(rd_en),
    .fifo_rd_data_i(rd_data), .fifo_rd_empty_i(empty), .fifo_rd_water_level_i(level),
    .m(m0), .busy_o(busy), .frame_cnt_o(fcnt)
  );
  fifo_frame_reader #(.FRAME_LEN(1)) u1 (
    .clk(clk), .rst_n(rst1_n), .enable_i(1'b1), .fifo_rd_en_o(rd_en1),
    .fifo_rd_data_i(rd_data1), .fifo_rd_empty_i(empty1), .fifo_rd_water_level_i(level1),
    .m(m1), .busy_o(busy1), .frame_cnt_o(fcnt1)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s got %0d want %0d", nm, act, exp);
    end
  endtask
  // FIFO models: read data appears in the cycle after the read enable
  always @(posedge clk) begin
    #2;
    rd_data = pend;
    empty = fq.size() == 0;
    level = 14'(fq.size());
    m0.ready = rdy_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
    rd_data1 = pend1;
    empty1 = f1.size() == 0;
    level1 = 14'(f1.size());
    m1.ready = 1'($urandom_range(0, 1));
  end
  always @(negedge clk) begin
    if (rst_n) begin
      if (eq.size() - fq.size() > max_out) max_out = eq.size() - fq.size();
      if (stall) ck("hold", {m0.valid, m0.sof, m0.eof, m0.data}, {1'b1, prev});
      stall = m0.valid && !m0.ready;
      prev = {m0.sof, m0.eof, m0.data};
      if (m0.valid && m0.ready) begin
        if (eq.size() == 0) ck("extra_word", 1, 0);
        else ck("data", m0.data, eq.pop_front());
        ck("sof", m0.sof, (k % FL) == 0);
        ck("eof", m0.eof, (k % FL) == FL - 1);
        if (gap_on != 0 && m0.sof && last_eof >= 0) ck("gap", cyc - last_eof, 4);
        if (m0.eof) begin
          eofs++;
          last_eof = cyc;
        end
        k++;
      end
      if (rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        if (fq.size() == 0) ck("rd_when_empty", 1, 0);
        else pend = fq.pop_front();
      end
    end else stall = 1'b0;
  end
  always @(negedge clk)
    if (rst1_n) begin
      if (m1.valid && m1.ready) begin
        if (e1.size() == 0) ck("fl1_extra", 1, 0);
        else ck("fl1_data", m1.data, e1.pop_front());
        ck("fl1_sof", m1.sof, 1);
        ck("fl1_eof", m1.eof, 1);
      end
      if (rd_en1) begin
        if (f1.size() == 0) ck("fl1_rd_empty", 1, 0);
        else pend1 = f1.pop_front();
      end
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int n);
    repeat (n) begin
      fq.push_back(wd);
      eq.push_back(wd);
      wd = wd + 11'd1;
    end
  endtask
  task automatic wait_eofs(input int n);
    int t = 0;
    while (eofs < n && t < 30000) begin
      tick();
      t++;
    end
    ck("frame_timeout", eofs >= n, 1);
  endtask
  task automatic wait_k(input int n);
    int t = 0;
    while (k < n && t < 30000) begin
      tick();
      t++;
    end
    ck("word_timeout", k >= n, 1);
  endtask
  initial begin
    wd = 11'd0;
    wd1 = 11'd100;
    rdy_rand = 1'b0;
    stall = 1'b0;
    enable = 1'b0;
    rst_n = 1'b0;
    rst1_n = 1'b0;
    repeat (3) tick();
    ck("rst_rd_en", rd_en, 0);
    ck("rst_valid", m0.valid, 0);
    ck("rst_sof", m0.sof, 0);
    ck("rst_eof", m0.eof, 0);
    ck("rst_busy", busy, 0);
    ck("rst_fcnt", fcnt, 0);
    ck("rst_data", m0.data, 0);
    rst_n = 1'b1;
    rst1_n = 1'b1;
    enable = 1'b1;
    repeat (8) begin
      f1.push_back(wd1);
      e1.push_back(wd1);
      wd1 = wd1 + 11'd1;
    end
    wr(FL - 1);
    repeat (20) tick();
    ck("no_rd_below_frame", rd_cnt, 0);
    wr(1);
    lvl_cyc = cyc;
    wait_eofs(1);
    ck("start_latency", first_rd - lvl_cyc, 1);
    ck("rd_frame1", rd_cnt, FL);
    repeat (2) tick();
    ck("fcnt_1", fcnt, 1);
    ck("idle_1", busy, 0);
    rdy_rand = 1'b1;
    wr(2 * FL);
    wait_eofs(3);
    ck("rd_frame3", rd_cnt, 3 * FL);
    ck("fcnt_3", fcnt, 3);
    wr(2 * FL);
    wait_k(3 * FL + 500);
    enable = 1'b0;
    wait_eofs(4);
    repeat (50) tick();
    ck("en_block_rd", rd_cnt, 4 * FL);
    ck("en_block_busy", busy, 0);
    ck("fcnt_4", fcnt, 4);
    enable = 1'b1;
    rdy_rand = 1'b0;
    wait_eofs(5);
    repeat (2) tick();
    gap_on = 1;
    last_eof = -1;
    wr(4 * FL);
    wait_eofs(9);
    gap_on = 0;
    repeat (2) tick();
    ck("fcnt_9", fcnt, 9);
    ck("rd_frame9", rd_cnt, 9 * FL);
    wr(FL);
    wait_k(9 * FL + 300);
    rst_n = 1'b0;
    #1;
    ck("arst_rd_en", rd_en, 0);
    ck("arst_valid", m0.valid, 0);
    ck("arst_sof", m0.sof, 0);
    ck("arst_eof", m0.eof, 0);
    ck("arst_busy", busy, 0);
    ck("arst_fcnt", fcnt, 0);
    while (eq.size() > fq.size()) void'(eq.pop_front());
    k = 0;
    eofs = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    wr(FL);
    wait_eofs(1);
    repeat (2) tick();
    ck("fcnt_after_rst", fcnt, 1);
    ck("max_outstanding_le2", max_out <= 2, 1);
    ck("fl1_frames", fcnt1, 8);
    ck("fl1_left", e1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
